// File: rtl/crop_pkg.sv
// Shared types and sizing helpers for the crop-filter frame scheduler.
package crop_pkg;

  typedef enum logic [1:0] {
    REARM = 2'd0,
    IDLE  = 2'd1,
    ISSUE = 2'd2,
    RUN   = 2'd3
  } state_e;

  // Pixels in a rows x cols window; used for both the full frame and the crop box.
  function automatic int frame_pix(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Command word: {Y1, X1} with Y1 in the MSBs.
  function automatic int cmd_width(input int row_bits, input int col_bits);
    return row_bits + col_bits;
  endfunction

  function automatic int cmd_y1_lsb(input int col_bits);
    return col_bits;
  endfunction

endpackage

// File: rtl/crop_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; DEPTH must be a power of 2.
module crop_cmd_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // A push into a full FIFO is legal only alongside a pop that frees the slot.
  assign rd_en_s = pop_i && !empty_o;
  assign wr_en_s = push_i && (!full_o || rd_en_s);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/crop_scheduler.sv
// Per-frame crop-box scheduler: queues {Y1,X1} commands, issues one per frame, rearms the filter.
// Optional build macro CROP_SCHED_CLAMP_EN clamps popped coordinates into the legal box range.
module crop_scheduler
  import crop_pkg::*;
#(
  parameter int IN_ROWS          = 40,
  parameter int IN_COLS          = 40,
  parameter int OUT_ROWS         = 20,
  parameter int OUT_COLS         = 20,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10,
  parameter int CMD_DEPTH        = 4,
  parameter int REARM_CYCLES     = 2
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH-1:0] cmd_TDATA,
  input  logic                                     cmd_TVALID,
  output logic                                     cmd_TREADY,
  output logic [IMG_ROW_BITWIDTH-1:0]              crop_Y1_TDATA,
  output logic                                     crop_Y1_TVALID,
  input  logic                                     crop_Y1_TREADY,
  output logic [IMG_COL_BITWIDTH-1:0]              crop_X1_TDATA,
  output logic                                     crop_X1_TVALID,
  input  logic                                     crop_X1_TREADY,
  output logic                                     filt_reset,
  input  logic                                     pix_in_TVALID,
  input  logic                                     pix_in_TREADY,
  input  logic                                     pix_out_TVALID,
  input  logic                                     pix_out_TREADY,
  output logic                                     frame_done,
  output logic [15:0]                              frame_count,
  output logic                                     crop_err,
  output logic                                     busy
);

  localparam int RB        = IMG_ROW_BITWIDTH;
  localparam int CB        = IMG_COL_BITWIDTH;
  localparam int CMD_W     = cmd_width(RB, CB);
  localparam int Y1_LSB    = cmd_y1_lsb(CB);
  localparam int FRAME_PIX = frame_pix(IN_ROWS, IN_COLS);
  localparam int CROP_PIX  = frame_pix(OUT_ROWS, OUT_COLS);
  localparam int CW        = cnt_width(FRAME_PIX);
  localparam int RW        = cnt_width(REARM_CYCLES);

  localparam logic [CW-1:0] LAST_PIX   = CW'(FRAME_PIX - 1);
  localparam logic [CW:0]   CROP_LIM   = (CW+1)'(CROP_PIX);
  localparam logic [RW-1:0] REARM_LAST = RW'(REARM_CYCLES - 1);

  state_e          state_q;
  logic [RW-1:0]   rearm_q;
  logic            filt_reset_q;
  logic [RB-1:0]   y1_q;
  logic [CB-1:0]   x1_q;
  logic            y1_vld_q;
  logic            x1_vld_q;
  logic [CW-1:0]   in_cnt_q;
  logic [CW-1:0]   out_cnt_q;
  logic            frame_done_q;
  logic [15:0]     frame_count_q;
  logic            crop_err_q;
  logic            busy_q;
  logic            cmd_rdy_q;

  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic            push_s;
  logic            pop_s;
  logic [CMD_W-1:0] fifo_dout_s;
  logic [RB-1:0]   raw_y1_s;
  logic [CB-1:0]   raw_x1_s;
  logic [RB-1:0]   pop_y1_s;
  logic [CB-1:0]   pop_x1_s;
  logic            y1_hs_s;
  logic            x1_hs_s;
  logic            in_hs_s;
  logic            out_hs_s;
  logic [CW:0]     out_next_s;

  // cmd_rdy_q keeps TREADY low for as long as reset is asserted.
  assign cmd_TREADY = cmd_rdy_q && !fifo_full_s;
  assign push_s     = cmd_TVALID && cmd_TREADY;
  assign pop_s      = (state_q == IDLE) && !fifo_empty_s;

  crop_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push_s),
    .data_i  (cmd_TDATA),
    .pop_i   (pop_s),
    .data_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign raw_y1_s = fifo_dout_s[Y1_LSB +: RB];
  assign raw_x1_s = fifo_dout_s[0 +: CB];

`ifdef CROP_SCHED_CLAMP_EN
  // X1 limit is one lower because the filter passes columns in (X1, X1+OUT_COLS].
  localparam logic [RB-1:0] Y1_MAX = RB'(IN_ROWS - OUT_ROWS);
  localparam logic [CB-1:0] X1_MAX = CB'(IN_COLS - OUT_COLS - 1);
  assign pop_y1_s = (raw_y1_s > Y1_MAX) ? Y1_MAX : raw_y1_s;
  assign pop_x1_s = (raw_x1_s > X1_MAX) ? X1_MAX : raw_x1_s;
`else
  assign pop_y1_s = raw_y1_s;
  assign pop_x1_s = raw_x1_s;
`endif

  assign y1_hs_s    = y1_vld_q && crop_Y1_TREADY;
  assign x1_hs_s    = x1_vld_q && crop_X1_TREADY;
  assign in_hs_s    = pix_in_TVALID && pix_in_TREADY;
  assign out_hs_s   = pix_out_TVALID && pix_out_TREADY;
  assign out_next_s = {1'b0, out_cnt_q} + (CW+1)'(out_hs_s);

  // Frame control FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= REARM;
      rearm_q       <= '0;
      filt_reset_q  <= 1'b1;
      y1_q          <= '0;
      x1_q          <= '0;
      y1_vld_q      <= 1'b0;
      x1_vld_q      <= 1'b0;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
      crop_err_q    <= 1'b0;
      busy_q        <= 1'b1;
      cmd_rdy_q     <= 1'b0;
    end else begin
      cmd_rdy_q    <= 1'b1;
      frame_done_q <= 1'b0;
      case (state_q)
        REARM: begin
          in_cnt_q  <= '0;
          out_cnt_q <= '0;
          if (rearm_q == REARM_LAST) begin
            state_q      <= IDLE;
            rearm_q      <= '0;
            filt_reset_q <= 1'b0;
            busy_q       <= 1'b0;
          end else begin
            rearm_q <= rearm_q + RW'(1);
          end
        end
        IDLE: begin
          if (pop_s) begin
            state_q  <= ISSUE;
            busy_q   <= 1'b1;
            y1_q     <= pop_y1_s;
            x1_q     <= pop_x1_s;
            y1_vld_q <= 1'b1;
            x1_vld_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (y1_hs_s) y1_vld_q <= 1'b0;
          if (x1_hs_s) x1_vld_q <= 1'b0;
          if ((!y1_vld_q || y1_hs_s) && (!x1_vld_q || x1_hs_s)) state_q <= RUN;
        end
        RUN: begin
          if (in_hs_s && (in_cnt_q == LAST_PIX)) begin
            state_q       <= REARM;
            rearm_q       <= '0;
            filt_reset_q  <= 1'b1;
            frame_done_q  <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            if (out_next_s != CROP_LIM) crop_err_q <= 1'b1;
          end else begin
            in_cnt_q  <= in_cnt_q + CW'(in_hs_s);
            out_cnt_q <= out_next_s[CW-1:0];
          end
        end
        default: begin
          state_q      <= REARM;
          rearm_q      <= '0;
          filt_reset_q <= 1'b1;
          busy_q       <= 1'b1;
        end
      endcase
    end
  end

  assign crop_Y1_TDATA  = y1_q;
  assign crop_Y1_TVALID = y1_vld_q;
  assign crop_X1_TDATA  = x1_q;
  assign crop_X1_TVALID = x1_vld_q;
  assign filt_reset     = filt_reset_q;
  assign frame_done     = frame_done_q;
  assign frame_count    = frame_count_q;
  assign crop_err       = crop_err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_crop_scheduler.sv
// Directed bench for crop_scheduler with a frame-level reference model and per-cycle compare.
`timescale 1ns/1ps
module tb_crop_scheduler;

  localparam int IN_ROWS = 40, IN_COLS = 40, OUT_ROWS = 20, OUT_COLS = 20;
  localparam int RB = 10, CB = 10, DEPTH = 4, REARM = 2;
  localparam int FRAME_PIX = IN_ROWS * IN_COLS;
  localparam int CROP_PIX  = OUT_ROWS * OUT_COLS;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [RB+CB-1:0] cmd_TDATA;
  logic          cmd_TVALID, cmd_TREADY;
  logic [RB-1:0] crop_Y1_TDATA;
  logic          crop_Y1_TVALID, crop_Y1_TREADY;
  logic [CB-1:0] crop_X1_TDATA;
  logic          crop_X1_TVALID, crop_X1_TREADY;
  logic          filt_reset;
  logic          pix_in_TVALID, pix_in_TREADY, pix_out_TVALID, pix_out_TREADY;
  logic          frame_done;
  logic [15:0]   frame_count;
  logic          crop_err, busy;

  crop_scheduler #(
    .IN_ROWS(IN_ROWS), .IN_COLS(IN_COLS), .OUT_ROWS(OUT_ROWS), .OUT_COLS(OUT_COLS),
    .IMG_ROW_BITWIDTH(RB), .IMG_COL_BITWIDTH(CB), .CMD_DEPTH(DEPTH), .REARM_CYCLES(REARM)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_TDATA(cmd_TDATA), .cmd_TVALID(cmd_TVALID), .cmd_TREADY(cmd_TREADY),
    .crop_Y1_TDATA(crop_Y1_TDATA), .crop_Y1_TVALID(crop_Y1_TVALID), .crop_Y1_TREADY(crop_Y1_TREADY),
    .crop_X1_TDATA(crop_X1_TDATA), .crop_X1_TVALID(crop_X1_TVALID), .crop_X1_TREADY(crop_X1_TREADY),
    .filt_reset(filt_reset),
    .pix_in_TVALID(pix_in_TVALID), .pix_in_TREADY(pix_in_TREADY),
    .pix_out_TVALID(pix_out_TVALID), .pix_out_TREADY(pix_out_TREADY),
    .frame_done(frame_done), .frame_count(frame_count), .crop_err(crop_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;
  logic drv_run = 1'b0;
  int exp_y[$];
  int exp_x[$];

  // Reference model state: frame totals derived only from the pixels the bench drives.
  int m_in, m_out, m_rearm;
  logic [15:0] m_cnt;
  logic m_err, m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_y1(input int y);
`ifdef CROP_SCHED_CLAMP_EN
    return (y > IN_ROWS - OUT_ROWS) ? IN_ROWS - OUT_ROWS : y;
`else
    return y;
`endif
  endfunction

  function automatic int model_x1(input int x);
`ifdef CROP_SCHED_CLAMP_EN
    return (x > IN_COLS - OUT_COLS - 1) ? IN_COLS - OUT_COLS - 1 : x;
`else
    return x;
`endif
  endfunction

  // A frame ends on its FRAME_PIX-th input beat; the filter is then held in reset REARM cycles.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_in <= 0; m_out <= 0; m_cnt <= 16'd0; m_err <= 1'b0; m_done <= 1'b0; m_rearm <= REARM;
    end else begin
      m_done  <= 1'b0;
      m_rearm <= (m_rearm > 0) ? m_rearm - 1 : 0;
      if (drv_run) begin
        if ((pix_in_TVALID && pix_in_TREADY) && (m_in + 1 == FRAME_PIX)) begin
          m_done  <= 1'b1;
          m_cnt   <= m_cnt + 16'd1;
          m_rearm <= REARM;
          m_in    <= 0;
          m_out   <= 0;
          if (m_out + int'(pix_out_TVALID && pix_out_TREADY) != CROP_PIX) m_err <= 1'b1;
        end else begin
          m_in  <= m_in + int'(pix_in_TVALID && pix_in_TREADY);
          m_out <= m_out + int'(pix_out_TVALID && pix_out_TREADY);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("frame_done", frame_done, m_done);
      chk("frame_count", frame_count, m_cnt);
      chk("crop_err", crop_err, m_err);
      chk("filt_reset", filt_reset, (m_rearm > 0) ? 1 : 0);
    end
  end

  task automatic push_cmd(input int y, input int x);
    int t;
    logic [RB-1:0] yv;
    logic [CB-1:0] xv;
    yv = y[RB-1:0];
    xv = x[CB-1:0];
    t = 0;
    cmd_TDATA  = {yv, xv};
    cmd_TVALID = 1'b1;
    while (!cmd_TREADY && t < 200) begin @(negedge clk); t++; end
    chk("cmd_accept", cmd_TREADY, 1);
    if (cmd_TREADY) begin
      @(posedge clk);
      exp_y.push_back(model_y1(y));
      exp_x.push_back(model_x1(x));
    end
    @(negedge clk);
    cmd_TVALID = 1'b0;
  endtask

  task automatic issue(input int xdelay);
    int t, ey, ex;
    ey = (exp_y.size() > 0) ? exp_y.pop_front() : -1;
    ex = (exp_x.size() > 0) ? exp_x.pop_front() : -1;
    t = 0;
    while (!crop_Y1_TVALID && t < 200) begin @(negedge clk); t++; end
    chk("y1_valid", crop_Y1_TVALID, 1);
    chk("x1_valid", crop_X1_TVALID, 1);
    chk("y1_data", crop_Y1_TDATA, ey);
    chk("x1_data", crop_X1_TDATA, ex);
    crop_Y1_TREADY = 1'b1;
    crop_X1_TREADY = (xdelay == 0);
    @(negedge clk);
    crop_Y1_TREADY = 1'b0;
    chk("y1_drop", crop_Y1_TVALID, 0);
    if (xdelay > 0) begin
      // Pixel beats while still issuing must not be counted toward the frame.
      pix_in_TVALID = 1'b1; pix_in_TREADY = 1'b1; pix_out_TVALID = 1'b1; pix_out_TREADY = 1'b1;
      for (int k = 0; k < xdelay; k++) begin
        chk("x1_hold", crop_X1_TVALID, 1);
        chk("x1_hold_data", crop_X1_TDATA, ex);
        @(negedge clk);
      end
      pix_in_TVALID = 1'b0; pix_in_TREADY = 1'b0; pix_out_TVALID = 1'b0; pix_out_TREADY = 1'b0;
      chk("x1_hold_end", crop_X1_TVALID, 1);
      crop_X1_TREADY = 1'b1;
      @(negedge clk);
      crop_X1_TREADY = 1'b0;
    end else begin
      crop_X1_TREADY = 1'b0;
    end
    chk("x1_drop", crop_X1_TVALID, 0);
  endtask

  task automatic run_frame(input int n_out, input int n_in);
    int ni, no, c;
    ni = 0; no = 0; c = 0;
    drv_run = 1'b1;
    while (ni < n_in) begin
      pix_in_TVALID  = (c % 7 != 3);
      pix_in_TREADY  = (c % 11 != 5);
      pix_out_TVALID = (no < n_out);
      pix_out_TREADY = 1'b1;
      @(posedge clk);
      if (pix_in_TVALID && pix_in_TREADY) ni++;
      if (pix_out_TVALID && pix_out_TREADY) no++;
      @(negedge clk);
      c++;
    end
    pix_in_TVALID = 1'b0; pix_in_TREADY = 1'b0; pix_out_TVALID = 1'b0; pix_out_TREADY = 1'b0;
    drv_run = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    cmd_TDATA = '0; cmd_TVALID = 1'b0;
    crop_Y1_TREADY = 1'b0; crop_X1_TREADY = 1'b0;
    pix_in_TVALID = 1'b0; pix_in_TREADY = 1'b0; pix_out_TVALID = 1'b0; pix_out_TREADY = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_filt_reset", filt_reset, 1);
    chk("rst_cmd_ready", cmd_TREADY, 0);
    chk("rst_y1_valid", crop_Y1_TVALID, 0);
    chk("rst_x1_valid", crop_X1_TVALID, 0);
    chk("rst_busy", busy, 1);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_y1_data", crop_Y1_TDATA, 0);
    chk("rst_x1_data", crop_X1_TDATA, 0);
    chk_en  = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rearm_c1", filt_reset, 1);
    @(negedge clk);
    chk("rearm_c2", filt_reset, 0);
    chk("idle_busy", busy, 0);

    // Frame 1: {10,5}, then fill the FIFO while the filter is mid-frame.
    push_cmd(10, 5);
    chk("pre_pop_valid", crop_Y1_TVALID, 0);
    @(negedge clk);
    chk("pop_latency_valid", crop_Y1_TVALID, 1);
    chk("first_y1", crop_Y1_TDATA, 10);
    chk("first_x1", crop_X1_TDATA, 5);
    issue(0);
    push_cmd(0, 0);
    push_cmd(20, 19);
    push_cmd(7, 13);
    push_cmd(1, 2);
    chk("fifo_full_ready", cmd_TREADY, 0);
    run_frame(400, FRAME_PIX);
    chk("f1_done", frame_done, 1);
    chk("f1_count", frame_count, 1);
    chk("f1_err", crop_err, 0);
    chk("f1_filt_a", filt_reset, 1);
    @(negedge clk);
    chk("f1_done_off", frame_done, 0);
    chk("f1_filt_b", filt_reset, 1);
    @(negedge clk);
    chk("f1_filt_c", filt_reset, 0);

    push_cmd(3, 4);
    issue(5);
    run_frame(400, FRAME_PIX);
    push_cmd(30, 30);
    for (int f = 0; f < 4; f++) begin
      issue(f % 2);
      run_frame(400, FRAME_PIX);
    end
    chk("f6_count", frame_count, 6);
    chk("f6_err", crop_err, 0);

    // Out-of-range box: an unclamped filter emits only 10 rows x 9 columns.
    issue(0);
`ifdef CROP_SCHED_CLAMP_EN
    run_frame(400, FRAME_PIX);
    chk("f7_err_clamped", crop_err, 0);
`else
    run_frame(90, FRAME_PIX);
    chk("f7_err_short", crop_err, 1);
`endif
    chk("f7_count", frame_count, 7);

    // Asynchronous reset in the middle of a frame with a command still queued.
    repeat (4) @(negedge clk);
    push_cmd(10, 5);
    issue(0);
    push_cmd(1, 1);
    run_frame(400, 700);
    chk_en = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_filt", filt_reset, 1);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_count", frame_count, 0);
    chk("mid_rst_err", crop_err, 0);
    chk("mid_rst_ready", cmd_TREADY, 0);
    chk("mid_rst_done", frame_done, 0);
    exp_y.delete();
    exp_x.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_empty", crop_Y1_TVALID, 0);
    chk("post_rst_ready", cmd_TREADY, 1);
    chk("post_rst_count", frame_count, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/crop_scheduler.md
Name: crop_scheduler

Overview:
Per-frame controller for the streaming crop filter. It queues crop-box commands (Y1, X1) from the host and issues one command per frame on the filter's crop_Y1/crop_X1 AXI-stream ports. It taps the filter's pixel handshakes to detect end of frame, then pulses the filter's reset so the next command can be accepted. It also reports frame completion, frame count and a sticky crop-count error.

Parameters:
IN_ROWS, 40, input frame height in pixels
IN_COLS, 40, input frame width in pixels
OUT_ROWS, 20, crop-box height
OUT_COLS, 20, crop-box width
IMG_ROW_BITWIDTH, 10, width of the row coordinate
IMG_COL_BITWIDTH, 10, width of the column coordinate
CMD_DEPTH, 4, command FIFO entries (power of 2, at least 2)
REARM_CYCLES, 2, cycles filt_reset is held high after each frame (at least 1)

Ports:
clk  in  1  single clock
reset_n  in  1  asynchronous active-low reset
cmd_TDATA  in  IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH  {Y1, X1}, Y1 in the MSBs
cmd_TVALID  in  1  command valid
cmd_TREADY  out  1  high when the FIFO is not full
crop_Y1_TDATA  out  IMG_ROW_BITWIDTH  Y1 to the filter
crop_Y1_TVALID  out  1
crop_Y1_TREADY  in  1
crop_X1_TDATA  out  IMG_COL_BITWIDTH  X1 to the filter
crop_X1_TVALID  out  1
crop_X1_TREADY  in  1
filt_reset  out  1  active-high synchronous reset driven to the filter
pix_in_TVALID, pix_in_TREADY  in  1 each  tap of the filter input handshake
pix_out_TVALID, pix_out_TREADY  in  1 each  tap of the filter output handshake
frame_done  out  1  one-cycle pulse at end of frame
frame_count  out  16  completed frames, wraps at 2^16
crop_err  out  1  sticky; set when a frame emits other than OUT_ROWS*OUT_COLS pixels
busy  out  1  high when state is not IDLE

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO emptied; state goes to REARM with the rearm counter at 0.
  - Output values: filt_reset=1, all TVALIDs 0, cmd_TREADY 0 while reset_n is low, frame_done 0, frame_count 0, crop_err 0, busy 1, coordinate TDATA outputs 0.
- Counter widths: FRAME_PIX = IN_ROWS*IN_COLS and CROP_PIX = OUT_ROWS*OUT_COLS. The in and out counters are $clog2(FRAME_PIX+1) bits wide.
- Command FIFO:
  - Push on cmd_TVALID&&cmd_TREADY. Pop only in IDLE.
  - Push and pop in the same cycle are both allowed when full or empty. No data passes straight through an empty FIFO, so a pop needs an entry present at the clock edge.
- REARM state:
  - filt_reset=1 for exactly REARM_CYCLES cycles, then go to IDLE with filt_reset=0.
  - The in and out pixel counters are cleared on entry.
- IDLE state:
  - If the FIFO is not empty, pop into registered Y1/X1 and go to ISSUE on the next cycle.
  - Otherwise stay in IDLE.
- ISSUE state:
  - On entry, crop_Y1_TVALID and crop_X1_TVALID both go high.
  - Each valid drops the cycle after its own handshake; the two handshakes are independent and may complete in either order or together.
  - When both are done, go to RUN.
  - TDATA is held stable while the matching TVALID is high.
- RUN state:
  - in_cnt increments on pix_in_TVALID&&pix_in_TREADY.
  - out_cnt increments on pix_out_TVALID&&pix_out_TREADY. Both can occur in the same cycle, and both are counted.
  - When an input handshake happens with in_cnt==FRAME_PIX-1:
    - next cycle: frame_done=1 for one cycle and frame_count+1;
    - crop_err is set if the final out_cnt (including that cycle's handshake) differs from CROP_PIX;
    - state goes to REARM.
  - Pixel handshakes seen outside RUN are ignored and not counted.
- Latency: a command popped in IDLE makes crop_*_TVALID high 1 cycle later. The minimum gap from the last pixel of one frame to the next coordinate issue is REARM_CYCLES+2 cycles.
- Command coordinates are not checked without the optional feature. An out-of-range box shows up only through crop_err.

Optional Feature:
Macro CROP_SCHED_CLAMP_EN.
- Defined: at pop, Y1 is clamped to at most IN_ROWS-OUT_ROWS and X1 to at most IN_COLS-OUT_COLS-1, because the filter passes x in (X1, X1+OUT_COLS]. This is a registered compare and select with no added latency.
- Not defined: coordinates pass through unmodified.

Decomposition:
- Package crop_pkg holds:
  - the state enum {REARM, IDLE, ISSUE, RUN};
  - the FRAME_PIX and CROP_PIX localparam functions;
  - the counter width function;
  - the cmd word layout (Y1 MSBs, X1 LSBs).
- One sub-module, crop_cmd_fifo: a synchronous FIFO with full/empty flags, parameterised on width and depth, sharing the same asynchronous active-low reset.

Test Plan:
- Reset, then cmd {Y1=10, X1=5}:
  - filt_reset high until 2 cycles after reset_n rises;
  - crop_Y1_TDATA=10 and crop_X1_TDATA=5 valid 1 cycle after the pop.
- Full 40x40 frame with 400 output handshakes: one frame_done pulse the cycle after input pixel 1599, frame_count=1, crop_err=0, filt_reset high for 2 cycles.
- 6 commands pushed with the filter stalled: cmd_TREADY drops after 4 entries; all 6 are issued in order over 6 frames.
- crop_X1_TREADY held low for 5 cycles after crop_Y1 completes: crop_Y1_TVALID drops the cycle after its handshake, crop_X1_TVALID stays high, and RUN is entered only after the X1 handshake.
- cmd {Y1=30, X1=30}:
  - without the macro, out_cnt is short and crop_err=1;
  - with CROP_SCHED_CLAMP_EN, the issued values are Y1=20, X1=19 and crop_err=0.
- reset_n pulsed low mid-RUN at pixel 700: all outputs return to their reset values immediately, the FIFO is empty, and frame_count=0.
